// File: rtl/hero_motion_pkg.sv
// rtl/hero_motion_pkg.sv - shared constants, FSM states and step helper for hero movement
package hero_motion_pkg;

  localparam int COORD_W   = 10;
  localparam int REGION_W  = 16;
  localparam int STEP      = 2;
  localparam int HERO_W    = 16;
  localparam int HERO_H    = 16;
  localparam int X_START   = 32;
  localparam int Y_START   = 32;
  localparam int X_MAX     = 639;
  localparam int Y_MAX     = 479;
  localparam int CELL      = 160;
  localparam int GRID_COLS = 4;
  localparam int GRID_ROWS = 3;

  localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(X_MAX - HERO_W + 1);
  localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(Y_MAX - HERO_H + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHK_X = 2'd1,
    ST_CHK_Y = 2'd2
  } state_e;

  // One axis step: inc/dec together or neither leaves the position alone.
  function automatic logic [COORD_W-1:0] step_coord(
    input logic [COORD_W-1:0] pos,
    input logic               inc,
    input logic               dec,
    input logic [COORD_W-1:0] limit
  );
    logic [COORD_W:0] sum;
    sum = {1'b0, pos} + (COORD_W+1)'(STEP);
    if (inc && !dec)
      step_coord = (sum > {1'b0, limit}) ? limit : sum[COORD_W-1:0];
    else if (dec && !inc)
      step_coord = (pos < COORD_W'(STEP)) ? '0 : pos - COORD_W'(STEP);
    else
      step_coord = pos;
  endfunction

endpackage

// File: rtl/hero_motion_if.sv
// rtl/hero_motion_if.sv - control, collision and position signals between hero_motion and its neighbours
interface hero_motion_if;
  import hero_motion_pkg::*;

  logic                tick;
  logic                btn_left;
  logic                btn_right;
  logic                btn_up;
  logic                btn_down;
  logic                coll;
  logic [REGION_W-1:0] active;
  logic [COORD_W-1:0]  hero_x;
  logic [COORD_W-1:0]  hero_y;
  logic [1:0]          blocked;
  logic                busy;

  modport master (
    output tick, btn_left, btn_right, btn_up, btn_down, coll,
    input  active, hero_x, hero_y, blocked, busy
  );

  modport slave (
    input  tick, btn_left, btn_right, btn_up, btn_down, coll,
    output active, hero_x, hero_y, blocked, busy
  );

endinterface

// File: rtl/hero_region.sv
// rtl/hero_region.sv - maps a sprite top-left position to its one-hot playfield region by centre point
module hero_region
  import hero_motion_pkg::*;
(
  input  logic [COORD_W-1:0]  x_i,
  input  logic [COORD_W-1:0]  y_i,
  output logic [REGION_W-1:0] region_o
);

  logic [COORD_W:0] cx;
  logic [COORD_W:0] cy;
  logic [1:0]       col;
  logic [1:0]       row;
  logic [3:0]       idx;

  // Compare chains stand in for divide-by-CELL; row clamps so bits 12..15 stay clear.
  always_comb begin
    cx = {1'b0, x_i} + (COORD_W+1)'(HERO_W / 2);
    cy = {1'b0, y_i} + (COORD_W+1)'(HERO_H / 2);
    if (cx >= (COORD_W+1)'(3 * CELL))      col = 2'd3;
    else if (cx >= (COORD_W+1)'(2 * CELL)) col = 2'd2;
    else if (cx >= (COORD_W+1)'(CELL))     col = 2'd1;
    else                                   col = 2'd0;
    if (cy >= (COORD_W+1)'((GRID_ROWS - 1) * CELL)) row = 2'd2;
    else if (cy >= (COORD_W+1)'(CELL))              row = 2'd1;
    else                                            row = 2'd0;
    idx      = 4'(row) * 4'(GRID_COLS) + 4'(col);
    region_o = REGION_W'(1) << idx;
  end

endmodule

// File: rtl/hero_motion.sv
// rtl/hero_motion.sv - per-tick hero movement: check x then y candidate region, commit only if clear
module hero_motion
  import hero_motion_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  hero_motion_if.slave  bus
);

  state_e              state_q;
  logic [COORD_W-1:0]  hero_x_q, hero_y_q;
  logic [COORD_W-1:0]  cand_x_q, cand_x_d;
  logic [COORD_W-1:0]  cand_y_q, cand_y_d;
  logic [COORD_W-1:0]  x_commit;
  logic                x_req_q, y_req_q;
  logic [REGION_W-1:0] active_q, region_x, region_y;
  logic [1:0]          blocked_q;
  logic                busy_q;

  always_comb begin
    cand_x_d = step_coord(hero_x_q, bus.btn_right, bus.btn_left, X_LIMIT);
    cand_y_d = step_coord(hero_y_q, bus.btn_down, bus.btn_up, Y_LIMIT);
    // The y check must see the x position as it will be after this frame's x decision.
    x_commit = bus.coll ? hero_x_q : cand_x_q;
  end

  hero_region u_region_x (.x_i(cand_x_d), .y_i(hero_y_q), .region_o(region_x));
  hero_region u_region_y (.x_i(x_commit), .y_i(cand_y_d), .region_o(region_y));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hero_x_q  <= COORD_W'(X_START);
      hero_y_q  <= COORD_W'(Y_START);
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      x_req_q   <= 1'b0;
      y_req_q   <= 1'b0;
      active_q  <= '0;
      blocked_q <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      blocked_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (bus.tick) begin
            cand_x_q <= cand_x_d;
            x_req_q  <= bus.btn_left ^ bus.btn_right;
            active_q <= region_x;
            busy_q   <= 1'b1;
            state_q  <= ST_CHK_X;
          end
        end
        ST_CHK_X: begin
          if (!bus.coll) hero_x_q <= cand_x_q;
          blocked_q[0] <= bus.coll & x_req_q;
          cand_y_q     <= cand_y_d;
          y_req_q      <= bus.btn_up ^ bus.btn_down;
          active_q     <= region_y;
          state_q      <= ST_CHK_Y;
        end
        ST_CHK_Y: begin
          if (!bus.coll) hero_y_q <= cand_y_q;
          blocked_q[1] <= bus.coll & y_req_q;
          active_q     <= '0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          active_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.active  = active_q;
  assign bus.hero_x  = hero_x_q;
  assign bus.hero_y  = hero_y_q;
  assign bus.blocked = blocked_q;
  assign bus.busy    = busy_q;

endmodule
